pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage that consumes the ALU `zero` branch flag and `ALU_result` to produce the next instruction address for the single-cycle RV32I core. It holds the architectural PC register, provides `pc_plus4` for JAL/JALR link writeback, and counts retired instructions. It can halt the core on a misaligned control-transfer target. Sits between the execute stage (ALU) and instruction memory address input.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 64: width of retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and counter this cycle.
- `branch`  in  1  current instruction is a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- `jump`  in  1  current instruction is JAL.
- `jalr`  in  1  current instruction is JALR.
- `zero`  in  1  ALU branch-condition flag; 1 = condition true.
- `ALU_result`  in  32  ALU output; JALR base+offset sum.
- `imm`  in  32  sign-extended immediate (B- or J-type offset).
- `pc`  out  32  current PC (instruction memory address).
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `instr_valid`  out  1  PC holds a fetchable instruction this cycle.
- `taken`  out  1  combinational: control transfer selected this cycle.
- `trap`  out  1  sticky misaligned-target halt flag.
- `trap_pc`  out  32  offending target address captured at trap.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT: entered on reset; `instr_valid`=0; PC held at `RESET_PC`; unconditional transition to RUN next cycle.
- RUN: `instr_valid`=1; PC updated every non-stalled cycle; -> HALT on misaligned target (macro enabled only).
- HALT: `instr_valid`=0, PC frozen, `instret` frozen; exit only by `reset`.
- Next-PC priority (RUN, `stall`=0): `jalr` -> `{ALU_result[31:1],1'b0}`; else `jump` -> `pc + imm`; else `branch & zero` -> `pc + imm`; else `pc + 4`.
- `taken` = RUN & ~stall & (jalr | jump | (branch & zero)); 0 in BOOT/HALT.
- All additions modulo 2^32; wrap-around silent (0xFFFF_FFFC + 4 = 0).
- `zero` ignored when `branch`=0.
- Misaligned: selected target with bit 1 set (no C extension; bit 0 already cleared for JALR, checked raw for `pc+imm`).
- `instret` increments by 1 each cycle in RUN with `stall`=0 and no trap this cycle; wraps at 2^CNT_W.

## Timing
- Reset values: `pc`=RESET_PC, `instr_valid`=0, `trap`=0, `trap_pc`=0, `instret`=0, state=BOOT.
- Reset asserted mid-operation (any state, incl. HALT, with stall) wins over all inputs on that edge.
- Next-PC is combinational from current-cycle inputs; `pc` updates on the following rising edge (1-cycle latency).
- `stall`=1: `pc`, `instret`, state unchanged; `taken`=0; no trap detection.
- Trap: on detecting edge, `trap`<=1, `trap_pc`<=bad target, `pc` NOT updated, state<=HALT.
- `pc_plus4` valid in every state, reflects current `pc`.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: misaligned-target detection, `trap`/`trap_pc` logic and HALT transition compiled in.
- Undefined: no detection; target bit 1 passes through unchanged (`pc` may become misaligned); `trap`, `trap_pc` tied to 0; HALT unreachable.

## Test plan
- Reset, release -> cycle 0 `pc`=0, `instr_valid`=0; cycle 1 `instr_valid`=1; 3 plain cycles -> `pc`=0x0C, `instret`=3.
- `pc`=0x100, `branch`=1, `zero`=1, `imm`=0xFFFF_FFF8 -> `taken`=1, next `pc`=0xF8; same with `zero`=0 -> `pc`=0x104, `taken`=0.
- `pc`=0x40, `jalr`=1, `jump`=1, `ALU_result`=0x201 -> `pc`=0x200 (jalr priority, bit 0 cleared), `pc_plus4`=0x44 before edge.
- With macro: `jalr`, `ALU_result`=0x206 -> `trap`=1, `trap_pc`=0x206, `pc` unchanged, `instr_valid`=0, stays halted until `reset`; without macro -> `pc`=0x206, `trap`=0.
- `stall`=1 for 4 cycles with `jump`=1 -> `pc`, `instret` unchanged, `taken`=0; `pc`=0xFFFF_FFFC no-branch -> `pc`=0x0.
- `reset` asserted during `stall` and in HALT -> next edge all outputs at reset values, state BOOT.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter, next-PC select and retired-instruction counter for the RV32I core.
// Define PC_MISALIGN_TRAP_EN to halt on a control-transfer target with bit 1 set.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             jump,
    input  logic             jalr,
    input  logic             zero,
    input  logic [31:0]      ALU_result,
    input  logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             instr_valid,
    output logic             taken,
    output logic             trap,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_imm;
    logic [31:0] next_pc;
    logic        run;
    logic        go;
    logic        misalign;

    assign run         = (state == RUN);
    assign go          = run & ~stall;
    assign instr_valid = run;
    assign pc_plus4    = pc + 32'd4;
    assign pc_imm      = pc + imm;
    assign taken       = go & (jalr | jump | (branch & zero));

    // jalr and jump may both be asserted; jalr wins
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            jalr:           next_pc = {ALU_result[31:1], 1'b0};
            jump:           next_pc = pc_imm;
            branch & zero:  next_pc = pc_imm;
            default:        next_pc = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = taken & next_pc[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            trap    <= 1'b0;
            trap_pc <= 32'd0;
        end else if (misalign) begin
            trap    <= 1'b1;
            trap_pc <= next_pc;
        end
    end
`else
    assign misalign = 1'b0;
    assign trap     = 1'b0;
    assign trap_pc  = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            instret <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (go) begin
                        if (misalign) begin
                            state <= HALT;
                        end else begin
                            pc      <= next_pc;
                            instret <= instret + CNT_W'(1);
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then random stimulus
// against a reference model of the PC stage behaviour.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, jump, jalr, zero;
    logic [31:0] ALU_result, imm;
    logic [31:0] pc, pc_plus4, trap_pc;
    logic        instr_valid, taken, trap;
    logic [63:0] instret;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .jump(jump), .jalr(jalr), .zero(zero), .ALU_result(ALU_result),
        .imm(imm), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .taken(taken), .trap(trap), .trap_pc(trap_pc), .instret(instret)
    );

    always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        v;
        logic        tk;
        logic        tr;
        logic [31:0] tpc;
        logic [63:0] ir;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: 0 = boot, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_tpc;
    logic        m_trap;
    logic [63:0] m_ir;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_tpc = 32'h0; m_trap = 1'b0; m_ir = 64'h0;
    endtask

    task automatic step(input bit r, input bit s, input bit br, input bit jp,
                        input bit jr, input bit z, input logic [31:0] alu,
                        input logic [31:0] im);
        exp_t e;
        logic [31:0] tgt;
        bit xfer;
        reset = r; stall = s; branch = br; jump = jp; jalr = jr; zero = z;
        ALU_result = alu; imm = im;
        xfer = jr || jp || (br && z);
        if (jr)               tgt = alu & 32'hFFFF_FFFE;
        else if (jp)          tgt = m_pc + im;
        else if (br && z)     tgt = m_pc + im;
        else                  tgt = m_pc + 32'd4;
        e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.v = (m_mode == 1);
        e.tk = (m_mode == 1) && !s && xfer;
        e.tr = m_trap; e.tpc = m_tpc; e.ir = m_ir;
        q.push_back(e);
        if (r) model_reset();
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && !s) begin
            if (TRAP_EN && xfer && tgt[1]) begin
                m_trap = 1'b1; m_tpc = tgt; m_mode = 2;
            end else begin
                m_pc = tgt; m_ir = m_ir + 64'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input bit s);
        step(1'b0, s, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic go_to(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", {32'h0, pc}, {32'h0, e.pc});
            chk("pc_plus4", {32'h0, pc_plus4}, {32'h0, e.pc4});
            chk("instr_valid", {63'h0, instr_valid}, {63'h0, e.v});
            chk("taken", {63'h0, taken}, {63'h0, e.tk});
            chk("trap", {63'h0, trap}, {63'h0, e.tr});
            chk("trap_pc", {32'h0, trap_pc}, {32'h0, e.tpc});
            chk("instret", instret, e.ir);
        end
    end

    initial begin
        logic [31:0] a, b;
        reset = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        zero = 1'b0; ALU_result = 32'h0; imm = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        plain(1'b0);
        plain(1'b0); plain(1'b0); plain(1'b0);
        go_to(32'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF8);
        go_to(32'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40);
        go_to(32'h40);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h201, 32'h80);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20);
        go_to(32'hFFFF_FFFC);
        plain(1'b0);
        plain(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20);
        plain(1'b0);
        plain(1'b0);
        go_to(32'h206);
        plain(1'b0); plain(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
        plain(1'b0); plain(1'b0);
        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            b = $urandom_range(0, 255) << 2;
            if ($urandom_range(0, 15) != 0) a[1] = 1'b0;
            if ($urandom_range(0, 1) != 0) b = -b;
            if ($urandom_range(0, 31) == 0) b[1] = 1'b1;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, a, b);
        end
        plain(1'b0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
